// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 codes,
// FSM states, channel structs and store lane formatting.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels plus the block-RAM port,
// bundled between the MEM stage, the responder and the BRAM.
interface dmem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // master is the pipeline together with the BRAM it talks through
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_load_align.sv
// Aligns a BRAM read word to the requested byte offset and sign- or
// zero-extends it according to the load funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder in front of a byte-enabled
// single-port BRAM, returning a registered, extended response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    dmem_req_t   req_p0;
    dmem_state_e state_q, state_d;
    logic        ready_p0, accept_p0, err_p0;
    logic [1:0]  cnt_q;
    logic [1:0]  off_p1;
    logic [2:0]  f3_p1;
    logic [31:0] ld_data_p1;
    dmem_rsp_t   rsp_p2;

    function automatic logic req_error(input dmem_req_t r);
        logic bad_align, bad_range, bad_f3;
        bad_align = (r.funct3[1:0] == 2'b01 && r.addr[0])
                 || (r.funct3[1:0] == 2'b10 && r.addr[1:0] != 2'b00);
        bad_range = (r.addr >> (ADDR_W + 2)) != 32'd0;
        bad_f3    = r.we ? (r.funct3 >= 3'b011)
                         : (r.funct3 == 3'b011 || r.funct3[2:1] == 2'b11);
        return bad_align | bad_range | bad_f3;
    endfunction

    assign req_p0 = '{we: bus.req_we, funct3: bus.req_funct3,
                      addr: bus.req_addr, wdata: bus.req_wdata};

    assign ready_p0  = (state_q == IDLE) && !rst;
    assign accept_p0 = bus.req_valid && ready_p0;
    assign err_p0    = req_error(req_p0);

    always_comb begin
        state_d       = state_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (accept_p0) begin
                    state_d = (err_p0 || req_p0.we) ? RESP : WAIT;
                    if (!err_p0) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = req_p0.addr[ADDR_W+1:2];
                        if (req_p0.we) begin
                            bus.mem_we    = store_be(req_p0.funct3[1:0], req_p0.addr[1:0]);
                            bus.mem_wdata = store_lanes(req_p0.funct3[1:0], req_p0.wdata);
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rsp_p2  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_p0) begin
                cnt_q <= 2'(READ_LATENCY - 1);
                if (err_p0 || req_p0.we) rsp_p2 <= '{rdata: 32'd0, err: err_p0};
            end
            if (state_q == WAIT) begin
                if (cnt_q != 2'd0) cnt_q  <= cnt_q - 2'd1;
                else               rsp_p2 <= '{rdata: ld_data_p1, err: 1'b0};
            end
        end
    end

    // p0 -> p1: load offset and type held until the BRAM word arrives
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            off_p1 <= req_p0.addr[1:0];
            f3_p1  <= req_p0.funct3;
        end
    end

    dmem_load_align u_align (
        .rdata  (bus.mem_rdata),
        .off    (off_p1),
        .funct3 (f3_p1),
        .data   (ld_data_p1)
    );

    assign bus.req_ready = ready_p0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_p2.rdata;
    assign bus.rsp_err   = rsp_p2.err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural BRAM and a byte-level
// shadow memory feeding an expected-response queue.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AW = 10;
    localparam int RL = 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(AW)) bus ();

    dmem_responder #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural BRAM, one-cycle read
    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            rd_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    logic [7:0] shadow [0:(4<<AW)-1];
    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int waits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
        int size;
        bit bad;
        logic [31:0] v;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad  = 0;
        if (we && f3 > 3'd2) bad = 1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1;
        if ((a % size) != 0) bad = 1;
        if (a >= (32'd4 << AW)) bad = 1;
        if (bad) begin
            sb_q.push_back('{rdata: 32'd0, err: 1'b1, lat: 8'd1});
        end else if (we) begin
            for (int i = 0; i < size; i++) shadow[12'(a + i)] = wd[8*i +: 8];
            sb_q.push_back('{rdata: 32'd0, err: 1'b0, lat: 8'd1});
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = shadow[12'(a + i)];
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            sb_q.push_back('{rdata: v, err: 1'b0, lat: 8'(RL + 1)});
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_en, input logic [3:0] exp_we,
                       input logic [31:0] exp_wd, input int stall, input string tag,
                       output int waited);
        exp_t e;
        int cyc;
        bit ok;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        ok = 0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1; break; end
            waited++;
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk({tag, " accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        chk({tag, " mem_en"}, 32'(bus.mem_en), 32'(exp_en));
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(exp_we));
        if (exp_en) chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(a[AW+1:2]));
        if (exp_en && we) chk({tag, " mem_wdata"}, bus.mem_wdata, exp_wd);
        model_push(we, f3, a, wd);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 1;
        ok  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin ok = 1; break; end
            cyc++;
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        if (!ok) begin
            chk({tag, " rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, " rdata"}, bus.rsp_rdata, e.rdata);
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(e.err));
        chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, " stall_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, " stall_rdata"}, bus.rsp_rdata, e.rdata);
            chk({tag, " stall_ready"}, 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (4 << AW); i++) shadow[i] = 8'h00;
        rst            = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h0000_0010;
        bus.req_wdata  = 32'h1234_5678;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        txn(1, F3_W,  32'h10, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 0, "sw",   waits);
        txn(0, F3_W,  32'h10, 32'h0,         1, 4'b0000, 32'h0,         0, "lw",   waits);
        txn(1, F3_B,  32'h13, 32'h0000_0080, 1, 4'b1000, 32'h8080_8080, 0, "sb",   waits);
        txn(0, F3_B,  32'h13, 32'h0,         1, 4'b0000, 32'h0,         0, "lb",   waits);
        txn(0, F3_BU, 32'h13, 32'h0,         1, 4'b0000, 32'h0,         0, "lbu",  waits);
        txn(1, F3_H,  32'h12, 32'h0000_7FFF, 1, 4'b1100, 32'h7FFF_7FFF, 0, "sh",   waits);
        txn(0, F3_H,  32'h12, 32'h0,         1, 4'b0000, 32'h0,         0, "lh",   waits);
        txn(0, F3_W,  32'h10, 32'h0,         1, 4'b0000, 32'h0,         0, "lw2",  waits);
        txn(1, F3_H,  32'h00, 32'hABCD_8001, 1, 4'b0011, 32'h8001_8001, 0, "sh0",  waits);
        txn(0, F3_H,  32'h00, 32'h0,         1, 4'b0000, 32'h0,         0, "lh0",  waits);
        txn(0, F3_HU, 32'h00, 32'h0,         1, 4'b0000, 32'h0,         0, "lhu0", waits);
        txn(1, F3_B,  32'h21, 32'h1234_5655, 1, 4'b0010, 32'h5555_5555, 0, "sb1",  waits);
        txn(0, F3_BU, 32'h21, 32'h0,         1, 4'b0000, 32'h0,         0, "lbu1", waits);

        txn(0, F3_W,  32'h0000_0002, 32'h0, 0, 4'b0000, 32'h0, 0, "err_lw_mis",   waits);
        txn(0, F3_H,  32'h0000_0001, 32'h0, 0, 4'b0000, 32'h0, 0, "err_lh_mis",   waits);
        txn(0, F3_W,  32'h0000_1000, 32'h0, 0, 4'b0000, 32'h0, 0, "err_range",    waits);
        txn(1, F3_H,  32'h0000_0003, 32'h1, 0, 4'b0000, 32'h0, 0, "err_sh_mis",   waits);
        txn(1, 3'b011, 32'h20,       32'h1, 0, 4'b0000, 32'h0, 0, "err_st_f3",    waits);
        txn(0, 3'b110, 32'h20,       32'h0, 0, 4'b0000, 32'h0, 0, "err_ld_f3",    waits);

        bus.rsp_ready = 1'b0;
        txn(0, F3_W,  32'h10, 32'h0, 1, 4'b0000, 32'h0, 5, "lw_stall", waits);
        txn(0, F3_BU, 32'h12, 32'h0, 1, 4'b0000, 32'h0, 0, "lbu_next", waits);
        chk("lbu_next accept_delay", 32'(waits), 32'd1);

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        @(negedge clk);
        chk("rstw accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rstw mem_en", 32'(bus.mem_en), 32'd0);
            chk("rstw rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rstw req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstw ready_after", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rstw no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;

        txn(1, F3_W, 32'h40, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D, 0, "sw_after", waits);
        txn(0, F3_W, 32'h40, 32'h0,         1, 4'b0000, 32'h0,         0, "lw_after", waits);

        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
